// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the 1-to-2 stream demux
//
// Purpose : select encoding and per-channel slot state shared by
//           demux_slot and demux1x2_stream.
// Contents: sel_t            destination select type (1 bit)
//           SEL_CH0/SEL_CH1  select values for channel 0 / channel 1
//           slot_st_t        output slot state (EMPTY / FULL)

package demux_pkg;

  typedef logic sel_t;

  localparam sel_t SEL_CH0 = 1'b0;
  localparam sel_t SEL_CH1 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_st_t;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output register with valid/ready for one demux channel
//
// Purpose : holds one beat for a single output channel. A load writes the
//           register and marks it full; a drain (valid && ready) empties it
//           unless a load lands in the same cycle, in which case the slot
//           stays full and takes the new data.
// Optional: DEMUX_CNT_EN adds a wrapping counter of drained beats.
// Ports   : clk        clock, rising edge
//           rst        synchronous active-high reset
//           load       write load_data into the slot this cycle
//           load_data  beat to store
//           ready      downstream consumer ready
//           valid      slot holds a beat
//           data       held beat
//           load_ok    slot can take a beat this cycle (!valid || ready)
//           cnt        drained-beat counter (DEMUX_CNT_EN only)

module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              load_ok
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("demux_slot: CNT_W must be at least 1");
  end

  slot_st_t st, st_nxt;
  logic     drain;

  assign valid   = (st == SLOT_FULL);
  assign drain   = valid && ready;
  // Full-and-draining still counts as free: the new beat replaces the one leaving.
  assign load_ok = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= SLOT_EMPTY;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      SLOT_EMPTY: if (load)           st_nxt = SLOT_FULL;
      SLOT_FULL:  if (drain && !load) st_nxt = SLOT_EMPTY;
      default:                        st_nxt = SLOT_EMPTY;
    endcase
  end

  // Data only moves on load, so a stalled slot holds its beat unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (drain) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/demux1x2_stream.sv
// rtl/demux1x2_stream.sv - registered 1-to-2 stream demultiplexer
//
// Purpose : routes each accepted input beat to channel 0 (s==0) or
//           channel 1 (s==1); each channel has its own one-entry output
//           register, so a stalled channel only blocks beats addressed to it.
// Optional: DEMUX_CNT_EN adds cnt0/cnt1 delivered-beat counters.
// Ports   : clk       clock, rising edge
//           rst       synchronous active-high reset
//           i_valid   input beat valid
//           i_ready   input beat accepted when i_valid && i_ready
//           i_data    input beat data
//           s         destination select, sampled with the beat
//           o0_valid / o0_ready / o0_data   channel 0 output stream
//           o1_valid / o1_ready / o1_data   channel 1 output stream
//           cnt0 / cnt1  beats delivered per channel (DEMUX_CNT_EN only)

module demux1x2_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  input  sel_t              s,
  output logic              o0_valid,
  input  logic              o0_ready,
  output logic [DATA_W-1:0] o0_data,
  output logic              o1_valid,
  input  logic              o1_ready,
  output logic [DATA_W-1:0] o1_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
`endif
);

  logic load0, load1;
  logic load_ok0, load_ok1;
  logic accept;

  // i_ready looks only at the addressed slot, never at i_valid.
  assign i_ready = (s == SEL_CH0) ? load_ok0 : load_ok1;
  assign accept  = i_valid && i_ready;
  assign load0   = accept && (s == SEL_CH0);
  assign load1   = accept && (s == SEL_CH1);

  demux_slot #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0),
    .load_data (i_data),
    .ready     (o0_ready),
    .valid     (o0_valid),
    .data      (o0_data),
    .load_ok   (load_ok0)
`ifdef DEMUX_CNT_EN
    ,
    .cnt       (cnt0)
`endif
  );

  demux_slot #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .load_data (i_data),
    .ready     (o1_ready),
    .valid     (o1_valid),
    .data      (o1_data),
    .load_ok   (load_ok1)
`ifdef DEMUX_CNT_EN
    ,
    .cnt       (cnt1)
`endif
  );

endmodule

// File: tb/tb_demux1x2_stream.sv
// tb/tb_demux1x2_stream.sv - scoreboard bench for demux1x2_stream

module tb_demux1x2_stream;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_valid = 1'b0;
  logic              i_ready;
  logic [DATA_W-1:0] i_data = '0;
  logic              s = 1'b0;
  logic              o0_valid, o1_valid;
  logic              o0_ready = 1'b0, o1_ready = 1'b0;
  logic [DATA_W-1:0] o0_data, o1_data;
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0]  cnt0, cnt1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];

  always #5 clk = ~clk;

  demux1x2_stream #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_data   (i_data),
    .s        (s),
    .o0_valid (o0_valid),
    .o0_ready (o0_ready),
    .o0_data  (o0_data),
    .o1_valid (o1_valid),
    .o1_ready (o1_ready),
    .o1_data  (o1_data)
`ifdef DEMUX_CNT_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Present a beat for one cycle; the expected acceptance is hand-computed by the caller.
  task automatic drive_beat(input logic [DATA_W-1:0] d, input logic sel, input logic exp_rdy,
                            input string name);
    i_valid = 1'b1;
    i_data  = d;
    s       = sel;
    @(negedge clk);
    chk(name, i_ready, exp_rdy);
    if (exp_rdy) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
  endtask

  // Monitor: every delivered beat must match the head of its channel queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (o0_valid === 1'b1 && o0_ready) begin
        if (q0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ch0_unexpected: got %0h, expected no beat", o0_data);
        end else begin
          chk("ch0_data", o0_data, q0.pop_front());
        end
      end
      if (o1_valid === 1'b1 && o1_ready) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ch1_unexpected: got %0h, expected no beat", o1_data);
        end else begin
          chk("ch1_data", o1_data, q1.pop_front());
        end
      end
    end
  end

  initial begin
    // T1: reset held two cycles with a beat offered
    rst = 1'b1; i_valid = 1'b1; i_data = 8'hFF; s = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("t1_o0_valid", o0_valid, 1'b0);
    chk("t1_o1_valid", o1_valid, 1'b0);
    chk("t1_o0_data", o0_data, 8'h00);
    chk("t1_o1_data", o1_data, 8'h00);
`ifdef DEMUX_CNT_EN
    chk("t1_cnt0", cnt0, 4'd0);
    chk("t1_cnt1", cnt1, 4'd0);
`endif
    next_cycle();
    rst = 1'b0; i_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("t1_post_o0_valid", o0_valid, 1'b0);

    // Idle beats (i_valid=0) do nothing whatever s/data hold
    next_cycle();
    i_valid = 1'b0; i_data = 8'h99; s = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("idle_o1_valid", o1_valid, 1'b0);

    // T2: routing with both consumers ready
    next_cycle();
    o0_ready = 1'b1; o1_ready = 1'b1;
    drive_beat(8'hA5, 1'b0, 1'b1, "t2_rdy_a5");
    next_cycle();
    drive_beat(8'h3C, 1'b1, 1'b1, "t2_rdy_3c");
    chk("t2_o0_valid_t1", o0_valid, 1'b1);
    chk("t2_o0_data_t1", o0_data, 8'hA5);
    chk("t2_o1_valid_t1", o1_valid, 1'b0);
    next_cycle();
    i_valid = 1'b0;
    @(negedge clk);
    chk("t2_o0_valid_t2", o0_valid, 1'b0);
    chk("t2_o1_valid_t2", o1_valid, 1'b1);
    chk("t2_o1_data_t2", o1_data, 8'h3C);
    next_cycle();
    @(negedge clk);
    chk("t2_o1_valid_t3", o1_valid, 1'b0);

    // T3: backpressure on ch0
    next_cycle();
    o0_ready = 1'b0;
    drive_beat(8'h11, 1'b0, 1'b1, "t3_rdy_11");
    next_cycle();
    drive_beat(8'h22, 1'b0, 1'b0, "t3_blocked_22");
    chk("t3_hold_data", o0_data, 8'h11);
    next_cycle();
    @(negedge clk);
    chk("t3_still_blocked", i_ready, 1'b0);
    chk("t3_hold_valid", o0_valid, 1'b1);
    chk("t3_hold_data2", o0_data, 8'h11);
    next_cycle();
    o0_ready = 1'b1;
    drive_beat(8'h22, 1'b0, 1'b1, "t3_rdy_22");
    next_cycle();
    i_valid = 1'b0;
    o0_ready = 1'b0;                 // leave ch0 stalled full for T4
    @(negedge clk);
    chk("t3_o0_valid_22", o0_valid, 1'b1);
    chk("t3_o0_data_22", o0_data, 8'h22);

    // T4: ch1 flows while ch0 is stalled full
    next_cycle();
    o1_ready = 1'b1;
    drive_beat(8'h44, 1'b1, 1'b1, "t4_rdy_44");
    next_cycle();
    i_valid = 1'b0; s = 1'b0;
    @(negedge clk);
    chk("t4_o1_valid", o1_valid, 1'b1);
    chk("t4_o1_data", o1_data, 8'h44);
    chk("t4_o0_valid", o0_valid, 1'b1);
    chk("t4_o0_data", o0_data, 8'h22);
    chk("t4_ch0_blocks", i_ready, 1'b0);
    next_cycle();
    o0_ready = 1'b1;                 // drain 0x22
    next_cycle();
    @(negedge clk);
    chk("t4_o0_drained", o0_valid, 1'b0);

    // T5: simultaneous load and drain on ch1
    next_cycle();
    o1_ready = 1'b0;
    drive_beat(8'h55, 1'b1, 1'b1, "t5_rdy_55");
    next_cycle();
    i_valid = 1'b0;
    @(negedge clk);
    chk("t5_o1_data_55", o1_data, 8'h55);
    next_cycle();
    o1_ready = 1'b1;
    drive_beat(8'h66, 1'b1, 1'b1, "t5_rdy_66");
    next_cycle();
    i_valid = 1'b0;
    @(negedge clk);
    chk("t5_o1_valid", o1_valid, 1'b1);
    chk("t5_o1_data_66", o1_data, 8'h66);
    next_cycle();
    @(negedge clk);
    chk("t5_o1_empty", o1_valid, 1'b0);

    // Reset during an active handshake: beat is not accepted
    next_cycle();
    rst = 1'b1; i_valid = 1'b1; i_data = 8'h77; s = 1'b0;
    next_cycle();
    rst = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("rst_hs_o0_valid", o0_valid, 1'b0);

`ifdef DEMUX_CNT_EN
    // T6: counter wrap with CNT_W=4, then reset mid-stream
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    o0_ready = 1'b1; o1_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      drive_beat(8'(k + 8'h80), 1'b0, 1'b1, "t6_rdy");
      next_cycle();
    end
    i_valid = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("t6_cnt0_wrap", cnt0, 4'd1);
    chk("t6_cnt1_zero", cnt1, 4'd0);
    next_cycle();
    drive_beat(8'hC1, 1'b0, 1'b1, "t6_mid_c1");
    next_cycle();
    drive_beat(8'hC2, 1'b1, 1'b1, "t6_mid_c2");
    next_cycle();
    i_valid = 1'b0;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_cnt0_rst", cnt0, 4'd0);
    chk("t6_cnt1_rst", cnt1, 4'd0);
`endif

    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("end_q0_empty", q0.size(), 0);
    chk("end_q1_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
